pwm_capture: RTL and testbench

//  Receive-side counterpart of the PWM generator: measures an incoming PWM waveform.

---
 rtl/pwm_pkg.sv | 5 +
 rtl/pwm_edge_sync.sv | 61 ++++++
 rtl/pwm_capture.sv | 103 ++++++++++
 tb/tb_pwm_capture.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared PWM definitions (capture FSM states, default counter width shared with the PWM generator)
package pwm_pkg;
  localparam int PWM_CNT_W = 16;
  typedef enum logic [1:0] {PC_IDLE, PC_WAIT_RISE, PC_MEASURE} pc_state_t;
endpackage

// File: rtl/pwm_edge_sync.sv
// pwm_edge_sync: synchronises pwm_i, optionally glitch-filters it, and flags rising edges.
//  Ports: clk, rst_n (async active-low), pwm_i (async PWM pin),
//         lvl_o (filtered level, aligned with rise_o), rise_o (1-cycle rising-edge flag).
//  PWM_CAPTURE_FILTER_EN defined: level changes only after FLT_CYCLES consecutive disagreeing cycles.
module pwm_edge_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int FLT_CYCLES  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_i,
  output logic lvl_o,
  output logic rise_o
);
  if (SYNC_STAGES < 2 || FLT_CYCLES < 1) begin : g_param_chk
    $error("pwm_edge_sync: SYNC_STAGES must be >= 2 and FLT_CYCLES >= 1");
  end
  logic [SYNC_STAGES-1:0] sync_q;
  logic lvl, lvl_dly_q, rise_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
  end
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FW = $clog2(FLT_CYCLES + 1);
  logic [FW-1:0] flt_q, flt_d;
  logic lvl_q, lvl_d;
  always_comb begin
    flt_d = '0;
    lvl_d = lvl_q;
    if (sync_q[SYNC_STAGES-1] != lvl_q) begin
      if (flt_q == FW'(FLT_CYCLES - 1)) lvl_d = sync_q[SYNC_STAGES-1];
      else                              flt_d = flt_q + FW'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_q <= '0;
      lvl_q <= 1'b0;
    end else begin
      flt_q <= flt_d;
      lvl_q <= lvl_d;
    end
  end
  assign lvl = lvl_q;
`else
  assign lvl = sync_q[SYNC_STAGES-1];
`endif
  // rise is registered; lvl_o is the delayed level so both line up on the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_dly_q <= 1'b0;
      rise_q    <= 1'b0;
    end else begin
      lvl_dly_q <= lvl;
      rise_q    <= lvl & ~lvl_dly_q;
    end
  end
  assign lvl_o  = lvl_dly_q;
  assign rise_o = rise_q;
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time (clk cycles) of an asynchronous PWM input.
//  Ports: clk, rst_n (async active-low), enable (low = idle, outputs hold), pwm_in (async),
//         period/high_time (last measurement), meas_valid (update pulse), overflow (no edge pulse).
//  PWM_CAPTURE_FILTER_EN defined: glitch filter of FLT_CYCLES cycles ahead of edge detection.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W       = PWM_CNT_W,
  parameter int SYNC_STAGES = 2,
  parameter int FLT_CYCLES  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             overflow
);
  pc_state_t state_q, state_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d, hcnt_q, hcnt_d, period_q, period_d, high_q, high_d;
  logic valid_q, valid_d, ovf_q, ovf_d, lvl, rise, full;
  pwm_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .FLT_CYCLES(FLT_CYCLES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pwm_i (pwm_in),
    .lvl_o (lvl),
    .rise_o(rise)
  );
  assign full = pcnt_q == '1;
  // period_cnt also runs while waiting for the aligning edge, so a static input keeps
  // reporting overflow every 2^CNT_W-1 cycles instead of going silent after the first one
  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    hcnt_d   = hcnt_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    ovf_d    = 1'b0;
    if (!enable) begin
      state_d = PC_IDLE;
      pcnt_d  = '0;
      hcnt_d  = '0;
    end else begin
      unique case (state_q)
        PC_IDLE: state_d = PC_WAIT_RISE;
        PC_WAIT_RISE: begin
          if (rise) begin
            state_d = PC_MEASURE;
            pcnt_d  = CNT_W'(1);
            hcnt_d  = CNT_W'(1);
          end else begin
            ovf_d  = full;
            pcnt_d = full ? CNT_W'(1) : pcnt_q + CNT_W'(1);
          end
        end
        PC_MEASURE: begin
          if (rise) begin
            period_d = pcnt_q;
            high_d   = hcnt_q;
            valid_d  = 1'b1;
            pcnt_d   = CNT_W'(1);
            hcnt_d   = CNT_W'(1);
          end else if (full) begin
            ovf_d   = 1'b1;
            state_d = PC_WAIT_RISE;
            pcnt_d  = CNT_W'(1);
            hcnt_d  = '0;
          end else begin
            pcnt_d = pcnt_q + CNT_W'(1);
            hcnt_d = hcnt_q + CNT_W'(lvl);
          end
        end
        default: state_d = PC_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PC_IDLE;
      pcnt_q   <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      hcnt_q   <= hcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end
  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = valid_q;
  assign overflow   = ovf_q;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: randomized and directed PWM stimulus checked against a waveform-level model
module tb_pwm_capture;
  localparam int W = 8, S = 2, FLT = 4, MAXC = (1 << W) - 1;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int LAT = S + 1 + FLT, DMIN = FLT;
`else
  localparam int LAT = S + 1, DMIN = 1;
`endif
  logic clk = 1'b0, rst_n, enable, pwm_in;
  logic [W-1:0] period, high_time;
  logic meas_valid, overflow;
  pwm_capture #(.CNT_W(W), .SYNC_STAGES(S), .FLT_CYCLES(FLT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .pwm_in    (pwm_in),
    .period    (period),
    .high_time (high_time),
    .meas_valid(meas_valid),
    .overflow  (overflow)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {int p; int h; int c;} meas_t;
  meas_t q[$];
  meas_t e_m;
  int n_chk = 0, n_fail = 0;
  logic cur = 1'b0;
  int prev_rise = -1, hi_cnt = 0, ovf_exp = 0, ovf_seen = 0, exp_p = 0, exp_h = 0, last_ovf = -1;
  bit static_chk = 1'b0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Model: measured quantities follow directly from the pin waveform -- the interval between
  // consecutive rises is the period, high cycles in that interval are the high time, and a gap
  // of g cycles without a rise yields (g-1)/(2^W-1) overflow pulses.
  task automatic rise(input int t);
    int g;
    if (prev_rise >= 0) begin
      g = t - prev_rise;
      ovf_exp += (g - 1) / MAXC;
      if (g <= MAXC) q.push_back('{p: g, h: hi_cnt, c: t + LAT});
    end
    prev_rise = t;
    hi_cnt = 0;
  endtask
  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      if (v && !cur) rise(cyc + 1);
      if (v) hi_cnt++;
      cur = v;
      pwm_in = v;
      tick();
    end
  endtask
  task automatic pulse(input int h, input int l);
    drive(1'b1, h);
    drive(1'b0, l);
  endtask
  task automatic glitch(input int n);
    pwm_in = 1'b1;
    repeat (n) tick();
    pwm_in = cur;
  endtask
  task automatic set_en(input logic v);
    enable = v;
    prev_rise = -1;
    hi_cnt = 0;
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (meas_valid || overflow) check("excl", {63'd0, meas_valid & overflow}, 0);
      if (meas_valid) begin
        check("meas_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          e_m = q.pop_front();
          check("period", period, e_m.p);
          check("high_time", high_time, e_m.h);
          check("latency", cyc, e_m.c);
          exp_p = e_m.p;
          exp_h = e_m.h;
        end
      end
      if (overflow) begin
        ovf_seen++;
        if (static_chk && last_ovf >= 0) check("ovf_gap", cyc - last_ovf, MAXC);
        last_ovf = cyc;
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0;
    enable = 1'b1;
    pwm_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pwm_in = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (i % 5 == 4) begin
        check("rst_period", period, 0);
        check("rst_high", high_time, 0);
        check("rst_valid", meas_valid, 0);
        check("rst_ovf", overflow, 0);
      end
    end
    pwm_in = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    drive(1'b0, 10);
    repeat (6) pulse(25, 75);
    repeat (3) pulse(DMIN, 100 - DMIN);
    repeat (3) pulse(100 - DMIN, DMIN);
    static_chk = 1'b1;
    last_ovf = -1;
    drive(1'b0, 700);
    last_ovf = -1;
    drive(1'b1, 700);
    static_chk = 1'b0;
    drive(1'b0, 50);
    repeat (2) pulse(25, 75);
    repeat (3) pulse(128, 127);
    repeat (3) pulse(128, 128);
    check("ovf_hold_period", period, exp_p);
    check("ovf_hold_high", high_time, exp_h);
    repeat (2) pulse(25, 75);
    drive(1'b1, 25);
    drive(1'b0, 40);
    set_en(1'b0);
    repeat (10) begin
      tick();
      check("en_hold_period", period, exp_p);
      check("en_hold_high", high_time, exp_h);
    end
    set_en(1'b1);
    drive(1'b0, 35);
    repeat (3) pulse(25, 75);
    drive(1'b1, 25);
    drive(1'b0, 30);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_period", period, 0);
    check("midrst_high", high_time, 0);
    check("midrst_valid", meas_valid, 0);
    check("midrst_ovf", overflow, 0);
    tick();
    rst_n = 1'b1;
    prev_rise = -1;
    hi_cnt = 0;
    drive(1'b0, 10);
    repeat (3) pulse(40, 60);
    repeat (30) pulse(int'($urandom_range(DMIN, 60)), int'($urandom_range(DMIN, 60)));
`ifdef PWM_CAPTURE_FILTER_EN
    repeat (4) begin
      drive(1'b1, 25);
      drive(1'b0, 20);
      glitch(3);
      drive(1'b0, 20);
      glitch(3);
      drive(1'b0, 29);
    end
    drive(1'b1, 25);
`endif
    drive(1'b0, 20);
    check("pending_meas", q.size(), 0);
    check("ovf_count", ovf_seen, ovf_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
